// File: rtl/jtag_dma_responder.sv
// jtag_dma_responder: system-clock DMA engine moving word blocks between memory and the ping-pong buffer
module jtag_dma_responder #(
   parameter int PP_ADDR_WIDTH = 9
) (
   input  logic                     system_clk,
   input  logic                     system_reset,
   input  logic [31:0]              DMA_address,
   input  logic                     DMA_launch_read,
   input  logic                     DMA_launch_write,
   input  logic                     DMA_launch_simple_switch,
   input  logic [3:0]               DMA_byte_enable,
   input  logic [7:0]               DMA_burst_size_OUT,
   input  logic [7:0]               DMA_block_size_OUT,
   output logic                     DMA_busy,
   output logic [7:0]               DMA_block_size_IN,
   output logic [PP_ADDR_WIDTH-1:0] pp_address,
   output logic                     pp_writeEnable,
   output logic [31:0]              pp_dataIn,
   input  logic [31:0]              pp_dataOut,
   output logic                     pp_switch,
   output logic                     bus_request,
   input  logic                     bus_grant,
   output logic                     bus_begin,
   output logic [31:0]              bus_address,
   output logic                     bus_read_n_write,
   output logic [7:0]               bus_burst_size,
   output logic [3:0]               bus_byte_enable,
   output logic [31:0]              bus_data_out,
   output logic                     bus_data_out_valid,
   input  logic [31:0]              bus_data_in,
   input  logic                     bus_data_in_valid,
   input  logic                     bus_busy,
   output logic                     bus_end
);
   typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_BEGIN, ST_RDATA, ST_WDATA, ST_END, ST_SWITCH} state_t;
   state_t                   state_q, state_d;
   logic [31:0]              addr_q, addr_d;
   logic [7:0]               n_q, n_d;
   logic [7:0]               b_q, b_d;
   logic [3:0]               be_q, be_d;
   logic                     rnw_q, rnw_d;
   logic                     rw_op_q, rw_op_d;
   logic [7:0]               words_q, words_d;
   logic [7:0]               left_q, left_d;
   logic [7:0]               last_q, last_d;
   logic [31:0]              skid_q, skid_d;
   logic                     skid_v_q, skid_v_d;
   logic                     busy_q, busy_d;
   logic [7:0]               blk_q, blk_d;
   logic [PP_ADDR_WIDTH-1:0] pp_addr_q, pp_addr_d;
   logic                     pp_we_q, pp_we_d;
   logic [31:0]              pp_din_q, pp_din_d;
   logic                     pp_sw_q, pp_sw_d;
   logic                     req_q, req_d;
   logic                     begin_q, begin_d;
   logic [31:0]              bus_addr_q, bus_addr_d;
   logic                     bus_rnw_q, bus_rnw_d;
   logic [7:0]               bus_bs_q, bus_bs_d;
   logic [3:0]               bus_be_q, bus_be_d;
   logic [31:0]              dout_q, dout_d;
   logic                     dout_v_q, dout_v_d;
   logic                     end_q, end_d;
   logic [7:0]               rem;
   logic [8:0]               bp1;
   logic [7:0]               len;
   logic [PP_ADDR_WIDTH-1:0] fetch_next;

   assign DMA_busy           = busy_q;
   assign DMA_block_size_IN  = blk_q;
   assign pp_address         = pp_addr_q;
   assign pp_writeEnable     = pp_we_q;
   assign pp_dataIn          = pp_din_q;
   assign pp_switch          = pp_sw_q;
   assign bus_request        = req_q;
   assign bus_begin          = begin_q;
   assign bus_address        = bus_addr_q;
   assign bus_read_n_write   = bus_rnw_q;
   assign bus_burst_size     = bus_bs_q;
   assign bus_byte_enable    = bus_be_q;
   assign bus_data_out       = dout_q;
   assign bus_data_out_valid = dout_v_q;
   assign bus_end            = end_q;

   // next-state and next-output computation; write path prefetches the buffer two words ahead with a one-word skid for stalls
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      n_d        = n_q;
      b_d        = b_q;
      be_d       = be_q;
      rnw_d      = rnw_q;
      rw_op_d    = rw_op_q;
      words_d    = words_q;
      left_d     = left_q;
      last_d     = last_q;
      skid_d     = skid_q;
      skid_v_d   = skid_v_q;
      blk_d      = blk_q;
      pp_addr_d  = pp_addr_q;
      pp_we_d    = 1'b0;
      pp_din_d   = pp_din_q;
      bus_addr_d = bus_addr_q;
      bus_rnw_d  = bus_rnw_q;
      bus_bs_d   = bus_bs_q;
      bus_be_d   = bus_be_q;
      dout_d     = dout_q;
      dout_v_d   = dout_v_q;
      rem        = n_q - words_q;
      bp1        = {1'b0, b_q} + 9'd1;
      len        = (bp1 < {1'b0, rem}) ? bp1[7:0] : rem;
      fetch_next = (pp_addr_q != PP_ADDR_WIDTH'(last_q)) ? pp_addr_q + PP_ADDR_WIDTH'(1) : pp_addr_q;
      case (state_q)
         ST_IDLE: begin
            if (DMA_launch_read || DMA_launch_write) begin
               addr_d  = DMA_address;
               n_d     = DMA_block_size_OUT;
               b_d     = DMA_burst_size_OUT;
               be_d    = DMA_byte_enable;
               rnw_d   = DMA_launch_read;
               rw_op_d = 1'b1;
               words_d = 8'd0;
               state_d = (DMA_block_size_OUT == 8'd0) ? ST_SWITCH : ST_REQ;
            end else if (DMA_launch_simple_switch) begin
               rw_op_d = 1'b0;
               state_d = ST_SWITCH;
            end
         end
         ST_REQ: begin
            if (bus_grant) begin
               state_d    = ST_BEGIN;
               bus_addr_d = addr_q + {22'd0, words_q, 2'b00};
               bus_bs_d   = len - 8'd1;
               bus_rnw_d  = rnw_q;
               bus_be_d   = be_q;
               left_d     = len;
               last_d     = words_q + len - 8'd1;
               pp_addr_d  = PP_ADDR_WIDTH'(words_q);
            end
         end
         ST_BEGIN: begin
            state_d   = rnw_q ? ST_RDATA : ST_WDATA;
            pp_addr_d = rnw_q ? pp_addr_q : fetch_next;
            skid_v_d  = 1'b0;
            dout_v_d  = 1'b0;
         end
         ST_RDATA: begin
            if (bus_data_in_valid) begin
               pp_we_d   = 1'b1;
               pp_din_d  = bus_data_in;
               pp_addr_d = PP_ADDR_WIDTH'(words_q);
               words_d   = words_q + 8'd1;
               left_d    = left_q - 8'd1;
               state_d   = (left_q == 8'd1) ? ST_END : ST_RDATA;
            end
         end
         ST_WDATA: begin
            if (!dout_v_q) begin
               dout_d    = pp_dataOut;
               dout_v_d  = 1'b1;
               pp_addr_d = fetch_next;
            end else if (!bus_busy) begin
               words_d = words_q + 8'd1;
               left_d  = left_q - 8'd1;
               if (left_q == 8'd1) begin
                  state_d  = ST_END;
                  dout_v_d = 1'b0;
               end else begin
                  dout_d    = skid_v_q ? skid_q : pp_dataOut;
                  skid_v_d  = 1'b0;
                  pp_addr_d = fetch_next;
               end
            end else if (!skid_v_q) begin
               skid_d   = pp_dataOut;
               skid_v_d = 1'b1;
            end
         end
         ST_END:    state_d = (words_q < n_q) ? ST_REQ : ST_SWITCH;
         ST_SWITCH: begin
            state_d = ST_IDLE;
            blk_d   = rw_op_q ? words_q : blk_q;
         end
         default:   state_d = ST_IDLE;
      endcase
      busy_d  = state_d != ST_IDLE;
      req_d   = state_d inside {ST_REQ, ST_BEGIN, ST_RDATA, ST_WDATA};
      begin_d = state_d == ST_BEGIN;
      end_d   = state_d == ST_END;
      pp_sw_d = state_d == ST_SWITCH;
   end

   // single register stage for state, datapath and all outputs; reset aborts any operation at once
   always_ff @(posedge system_clk or posedge system_reset) begin
      if (system_reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         n_q        <= '0;
         b_q        <= '0;
         be_q       <= '0;
         rnw_q      <= 1'b0;
         rw_op_q    <= 1'b0;
         words_q    <= '0;
         left_q     <= '0;
         last_q     <= '0;
         skid_q     <= '0;
         skid_v_q   <= 1'b0;
         busy_q     <= 1'b0;
         blk_q      <= '0;
         pp_addr_q  <= '0;
         pp_we_q    <= 1'b0;
         pp_din_q   <= '0;
         pp_sw_q    <= 1'b0;
         req_q      <= 1'b0;
         begin_q    <= 1'b0;
         bus_addr_q <= '0;
         bus_rnw_q  <= 1'b0;
         bus_bs_q   <= '0;
         bus_be_q   <= '0;
         dout_q     <= '0;
         dout_v_q   <= 1'b0;
         end_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         n_q        <= n_d;
         b_q        <= b_d;
         be_q       <= be_d;
         rnw_q      <= rnw_d;
         rw_op_q    <= rw_op_d;
         words_q    <= words_d;
         left_q     <= left_d;
         last_q     <= last_d;
         skid_q     <= skid_d;
         skid_v_q   <= skid_v_d;
         busy_q     <= busy_d;
         blk_q      <= blk_d;
         pp_addr_q  <= pp_addr_d;
         pp_we_q    <= pp_we_d;
         pp_din_q   <= pp_din_d;
         pp_sw_q    <= pp_sw_d;
         req_q      <= req_d;
         begin_q    <= begin_d;
         bus_addr_q <= bus_addr_d;
         bus_rnw_q  <= bus_rnw_d;
         bus_bs_q   <= bus_bs_d;
         bus_be_q   <= bus_be_d;
         dout_q     <= dout_d;
         dout_v_q   <= dout_v_d;
         end_q      <= end_d;
      end
   end
endmodule

// File: tb/tb_jtag_dma_responder.sv
// tb_jtag_dma_responder: scoreboard bench with bus slave and ping-pong buffer models
module tb_jtag_dma_responder;
   logic        system_clk = 1'b0;
   logic        system_reset;
   logic [31:0] DMA_address;
   logic        DMA_launch_read, DMA_launch_write, DMA_launch_simple_switch;
   logic [3:0]  DMA_byte_enable;
   logic [7:0]  DMA_burst_size_OUT, DMA_block_size_OUT;
   logic        DMA_busy;
   logic [7:0]  DMA_block_size_IN;
   logic [8:0]  pp_address;
   logic        pp_writeEnable;
   logic [31:0] pp_dataIn, pp_dataOut;
   logic        pp_switch, bus_request, bus_grant, bus_begin;
   logic [31:0] bus_address;
   logic        bus_read_n_write;
   logic [7:0]  bus_burst_size;
   logic [3:0]  bus_byte_enable;
   logic [31:0] bus_data_out;
   logic        bus_data_out_valid;
   logic [31:0] bus_data_in;
   logic        bus_data_in_valid, bus_busy, bus_end;

   int n_chk = 0, n_fail = 0;
   int n_sw, n_end, n_req, n_begin, n_ppw;
   int rd_left = 0, wb_idx, stall_beat, stall_len, stall_cnt;
   logic [31:0] rd_addr;
   logic [63:0] exp_b[$], exp_pp[$], exp_w[$];
   logic        tb_we = 1'b0;
   logic [7:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;
   logic [31:0] ppmem [256];
   logic        any_out;

   assign any_out = |{DMA_busy, DMA_block_size_IN, pp_address, pp_writeEnable, pp_dataIn, pp_switch,
                      bus_request, bus_begin, bus_address, bus_read_n_write, bus_burst_size,
                      bus_byte_enable, bus_data_out, bus_data_out_valid, bus_end};

   always #5 system_clk = ~system_clk;

   jtag_dma_responder #(.PP_ADDR_WIDTH(9)) dut (
      .system_clk(system_clk), .system_reset(system_reset), .DMA_address(DMA_address),
      .DMA_launch_read(DMA_launch_read), .DMA_launch_write(DMA_launch_write),
      .DMA_launch_simple_switch(DMA_launch_simple_switch), .DMA_byte_enable(DMA_byte_enable),
      .DMA_burst_size_OUT(DMA_burst_size_OUT), .DMA_block_size_OUT(DMA_block_size_OUT),
      .DMA_busy(DMA_busy), .DMA_block_size_IN(DMA_block_size_IN), .pp_address(pp_address),
      .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn), .pp_dataOut(pp_dataOut),
      .pp_switch(pp_switch), .bus_request(bus_request), .bus_grant(bus_grant), .bus_begin(bus_begin),
      .bus_address(bus_address), .bus_read_n_write(bus_read_n_write), .bus_burst_size(bus_burst_size),
      .bus_byte_enable(bus_byte_enable), .bus_data_out(bus_data_out),
      .bus_data_out_valid(bus_data_out_valid), .bus_data_in(bus_data_in),
      .bus_data_in_valid(bus_data_in_valid), .bus_busy(bus_busy), .bus_end(bus_end)
   );

   // buffer model: synchronous read with one cycle latency, plus a bench-side preload port
   always @(posedge system_clk) begin
      if (pp_writeEnable) ppmem[pp_address[7:0]] <= pp_dataIn;
      if (tb_we) ppmem[tb_wa] <= tb_wd;
      pp_dataOut <= ppmem[pp_address[7:0]];
   end

   function automatic logic [31:0] sysmem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_sw = 0; n_end = 0; n_req = 0; n_begin = 0; n_ppw = 0;
      wb_idx = 0; stall_beat = -1; stall_len = 0; stall_cnt = 0;
   endtask

   task automatic push_bursts(input logic [31:0] a, input int n, input int b, input logic rnw, input logic [3:0] be);
      for (int w = 0; w < n; w += b + 1) begin
         int sz = (n - w < b + 1) ? n - w : b + 1;
         exp_b.push_back({19'd0, be, a + 32'(4 * w), 8'(sz - 1), rnw});
      end
   endtask

   task automatic push_read(input logic [31:0] a, input int n, input int b, input logic [3:0] be);
      push_bursts(a, n, b, 1'b1, be);
      for (int i = 0; i < n; i++) exp_pp.push_back({32'(i), sysmem(a + 32'(4 * i))});
   endtask

   task automatic launch(input logic rd, input logic wr, input logic sw, input logic [31:0] a,
                         input logic [7:0] n, input logic [7:0] b, input logic [3:0] be);
      @(negedge system_clk);
      DMA_address = a; DMA_block_size_OUT = n; DMA_burst_size_OUT = b; DMA_byte_enable = be;
      DMA_launch_read = rd; DMA_launch_write = wr; DMA_launch_simple_switch = sw;
      @(negedge system_clk);
      DMA_launch_read = 1'b0; DMA_launch_write = 1'b0; DMA_launch_simple_switch = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (DMA_busy && k < 400) begin
         @(negedge system_clk);
         k++;
      end
      chk(tag, 64'(k < 400), 64'd1);
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge system_clk);
      tb_we = 1'b1; tb_wa = a; tb_wd = d;
      @(negedge system_clk);
      tb_we = 1'b0;
   endtask

   // bus slave and output monitors, all evaluated at the falling edge
   initial begin
      bus_grant = 1'b0; bus_data_in_valid = 1'b0; bus_busy = 1'b0; bus_data_in = '0;
      clr();
      forever begin
         @(negedge system_clk);
         bus_grant = bus_request;
         bus_data_in_valid = 1'b0;
         bus_busy = 1'b0;
         if (system_reset) rd_left = 0;
         if (rd_left > 0) begin
            bus_data_in_valid = 1'b1;
            bus_data_in = sysmem(rd_addr);
            rd_addr += 32'd4;
            rd_left--;
         end
         if (bus_switch_seen()) n_sw++;
         if (bus_end) n_end++;
         if (bus_request) n_req++;
         if (bus_begin) begin
            n_begin++;
            if (bus_read_n_write) begin
               rd_left = int'(bus_burst_size) + 1;
               rd_addr = bus_address;
            end
            if (exp_b.size() == 0) chk("burst_unexpected", 64'(exp_b.size()), 64'd1);
            else chk("burst", {19'd0, bus_byte_enable, bus_address, bus_burst_size, bus_read_n_write}, exp_b.pop_front());
         end
         if (pp_writeEnable) begin
            n_ppw++;
            if (exp_pp.size() == 0) chk("ppw_unexpected", 64'(exp_pp.size()), 64'd1);
            else chk("ppw", {23'd0, pp_address, pp_dataIn}, exp_pp.pop_front());
         end
         if (bus_data_out_valid) begin
            bus_busy = (wb_idx == stall_beat) && (stall_cnt < stall_len);
            if (bus_busy) stall_cnt++;
            if (exp_w.size() == 0) chk("wbeat_unexpected", 64'(exp_w.size()), 64'd1);
            else begin
               chk("wbeat", 64'(bus_data_out), exp_w[0]);
               if (!bus_busy) begin
                  void'(exp_w.pop_front());
                  wb_idx++;
               end
            end
         end
      end
   end

   function automatic logic bus_switch_seen();
      return pp_switch;
   endfunction

   initial begin
      system_reset = 1'b1;
      DMA_address = '0; DMA_launch_read = 1'b0; DMA_launch_write = 1'b0; DMA_launch_simple_switch = 1'b0;
      DMA_byte_enable = '0; DMA_burst_size_OUT = '0; DMA_block_size_OUT = '0;
      repeat (3) @(negedge system_clk);
      chk("reset_outputs", 64'(any_out), 64'd0);
      system_reset = 1'b0;

      clr();
      push_read(32'h100, 4, 3, 4'hF);
      launch(1'b1, 1'b0, 1'b0, 32'h100, 8'd4, 8'd3, 4'hF);
      chk("t1_busy_t1", 64'(DMA_busy), 64'd1);
      wait_idle("t1_done");
      chk("t1_blk", 64'(DMA_block_size_IN), 64'd4);
      chk("t1_switch", 64'(n_sw), 64'd1);
      chk("t1_ends", 64'(n_end), 64'd1);
      chk("t1_pending", 64'(exp_b.size() + exp_pp.size()), 64'd0);

      clr();
      push_read(32'h100, 10, 3, 4'hF);
      launch(1'b1, 1'b0, 1'b0, 32'h100, 8'd10, 8'd3, 4'hF);
      wait_idle("t2_done");
      chk("t2_blk", 64'(DMA_block_size_IN), 64'd10);
      chk("t2_ends", 64'(n_end), 64'd3);
      chk("t2_switch", 64'(n_sw), 64'd1);
      chk("t2_pending", 64'(exp_b.size() + exp_pp.size()), 64'd0);

      preload(8'd0, 32'hAAAA_0001);
      preload(8'd1, 32'hBBBB_0002);
      preload(8'd2, 32'hCCCC_0003);
      clr();
      stall_beat = 1; stall_len = 2;
      push_bursts(32'h400, 3, 7, 1'b0, 4'h3);
      exp_w.push_back(64'hAAAA_0001);
      exp_w.push_back(64'hBBBB_0002);
      exp_w.push_back(64'hCCCC_0003);
      launch(1'b0, 1'b1, 1'b0, 32'h400, 8'd3, 8'd7, 4'h3);
      wait_idle("t3_done");
      chk("t3_blk", 64'(DMA_block_size_IN), 64'd3);
      chk("t3_stalls", 64'(stall_cnt), 64'd2);
      chk("t3_pending", 64'(exp_b.size() + exp_w.size()), 64'd0);
      chk("t3_switch", 64'(n_sw), 64'd1);

      clr();
      launch(1'b0, 1'b0, 1'b1, 32'h0, 8'd5, 8'd0, 4'h0);
      chk("t4_switch_t1", 64'(pp_switch), 64'd1);
      chk("t4_busy_t1", 64'(DMA_busy), 64'd1);
      @(negedge system_clk);
      chk("t4_busy_t2", 64'(DMA_busy), 64'd0);
      chk("t4_blk_kept", 64'(DMA_block_size_IN), 64'd3);
      launch(1'b1, 1'b0, 1'b0, 32'h700, 8'd0, 8'd3, 4'hF);
      wait_idle("t4_n0_done");
      @(negedge system_clk);
      chk("t4_blk_n0", 64'(DMA_block_size_IN), 64'd0);
      chk("t4_switches", 64'(n_sw), 64'd2);
      chk("t4_no_req", 64'(n_req), 64'd0);

      clr();
      push_read(32'h300, 4, 1, 4'h5);
      launch(1'b1, 1'b1, 1'b0, 32'h300, 8'd4, 8'd1, 4'h5);
      DMA_address = 32'h900; DMA_launch_write = 1'b1;
      @(negedge system_clk);
      DMA_launch_write = 1'b0;
      wait_idle("t5_done");
      repeat (5) @(negedge system_clk);
      chk("t5_idle", 64'(DMA_busy), 64'd0);
      chk("t5_blk", 64'(DMA_block_size_IN), 64'd4);
      chk("t5_begins", 64'(n_begin), 64'd2);
      chk("t5_pending", 64'(exp_b.size() + exp_pp.size()), 64'd0);

      clr();
      push_read(32'h200, 8, 7, 4'hF);
      launch(1'b1, 1'b0, 1'b0, 32'h200, 8'd8, 8'd7, 4'hF);
      for (int k = 0; k < 100 && n_ppw < 2; k++) @(negedge system_clk);
      chk("t6_mid_busy", 64'(DMA_busy), 64'd1);
      #2 system_reset = 1'b1;
      #1 chk("t6_reset_outputs", 64'(any_out), 64'd0);
      repeat (2) @(negedge system_clk);
      exp_b.delete();
      exp_pp.delete();
      system_reset = 1'b0;
      repeat (2) @(negedge system_clk);
      chk("t6_no_switch", 64'(n_sw), 64'd0);
      chk("t6_blk_cleared", 64'(DMA_block_size_IN), 64'd0);
      clr();
      push_read(32'h500, 2, 3, 4'hF);
      launch(1'b1, 1'b0, 1'b0, 32'h500, 8'd2, 8'd3, 4'hF);
      wait_idle("t6_done");
      chk("t6_blk", 64'(DMA_block_size_IN), 64'd2);
      chk("t6_switch", 64'(n_sw), 64'd1);
      chk("t6_pending", 64'(exp_b.size() + exp_pp.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
